// File: rtl/foo_array_gather_if.sv
// foo_array_gather_if: handshake bundle for the serial-to-array collector.
//   Input side : in_valid, in_bit, flush (producer -> collector), in_ready (collector -> producer)
//   Output side: out_valid, out_foo[W-1:0], out_len (collector -> consumer),
//                out_ready (consumer -> collector)
//   master : the environment (producer and consumer)
//   slave  : the collector itself
interface foo_array_gather_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned LW = $clog2(W + 1)
);
    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic          out_foo [W-1:0];
    logic [LW-1:0] out_len;

    modport master (
        output in_valid, in_bit, flush, out_ready,
        input  in_ready, out_valid, out_foo, out_len
    );

    modport slave (
        input  in_valid, in_bit, flush, out_ready,
        output in_ready, out_valid, out_foo, out_len
    );
endinterface

// File: rtl/foo_array_gather.sv
// foo_array_gather: collects one bit per valid/ready beat into an unpacked array of W
// elements (element 0 first). A flush closes a partial array early. Completed arrays sit in
// an output register until the consumer takes them; if the register is still occupied when
// an array completes, the collector stalls its input (FULL) holding the array in place.
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : foo_array_gather_if.slave
//          in_valid/in_bit/in_ready/flush : serial input side
//          out_valid/out_ready/out_foo/out_len : array output side
module foo_array_gather #(
    parameter int unsigned W  = 4,
    parameter int unsigned LW = $clog2(W + 1)
) (
    input logic               clk,
    input logic               rst,
    foo_array_gather_if.slave bus
);
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] IdxLast = IW'(W - 1);

    typedef enum logic [0:0] {StFill, StFull} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  asm_q, asm_d;
    logic [LW-1:0] len_q, len_d;          // length of the array parked in asm while FULL
    logic [W-1:0]  out_q, out_d;
    logic [LW-1:0] out_len_q, out_len_d;
    logic          out_valid_q, out_valid_d;

    logic          accept;
    logic          slot_free;
    logic          complete;
    logic [LW-1:0] count;
    logic [W-1:0]  asm_next;

    always_comb begin
        accept    = bus.in_valid && (state_q == StFill);
        slot_free = !out_valid_q || bus.out_ready;
        count     = LW'(idx_q) + LW'(accept);

        // Elements above the fill point are always 0 in asm, so asm_next is already
        // zero-padded beyond the array length.
        asm_next = asm_q;
        for (int i = 0; i < W; i++) begin
            if (accept && (idx_q == IW'(i))) begin
                asm_next[i] = bus.in_bit;
            end
        end

        complete = (state_q == StFill) &&
                   ((accept && (idx_q == IdxLast)) || (bus.flush && (count != '0)));
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        len_d       = len_q;
        out_d       = out_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q && !bus.out_ready;

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    asm_d = asm_next;
                    idx_d = idx_q + IW'(1);
                end
                if (complete) begin
                    idx_d = '0;
                    if (slot_free) begin
                        out_d       = asm_next;
                        out_len_d   = count;
                        out_valid_d = 1'b1;
                        asm_d       = '0;
                    end else begin
                        state_d = StFull;
                        len_d   = count;
                    end
                end
            end
            StFull: begin
                if (slot_free) begin
                    out_d       = asm_q;
                    out_len_d   = len_q;
                    out_valid_d = 1'b1;
                    asm_d       = '0;
                    idx_d       = '0;
                    state_d     = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFill;
            idx_q       <= '0;
            asm_q       <= '0;
            len_q       <= '0;
            out_q       <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            len_q       <= len_d;
            out_q       <= out_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == StFill);
        bus.out_valid = out_valid_q;
        bus.out_len   = out_len_q;
        for (int i = 0; i < W; i++) begin
            bus.out_foo[i] = out_q[i];
        end
    end
endmodule

// File: tb/tb_foo_array_gather.sv
// tb_foo_array_gather: directed table of per-cycle vectors for a W=4 collector, hand-written
// sequences for asynchronous reset and a W=1 collector, and a random-handshake scoreboard run.
module tb_foo_array_gather;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    foo_array_gather_if #(.W(4)) bus4 ();
    foo_array_gather_if #(.W(1)) bus1 ();

    foo_array_gather #(.W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    foo_array_gather #(.W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [3:0] foo4;
    always_comb begin
        for (int i = 0; i < 4; i++) foo4[i] = bus4.out_foo[i];
    end

    // One vector = inputs for one cycle and expected outputs just after that cycle's edge.
    // exp_foo bit i is array element i.
    typedef struct {
        logic       iv, din, fl, ordy;
        logic       exp_rdy, exp_ov;
        logic [3:0] exp_foo;
        logic [2:0] exp_len;
    } vec_t;

    typedef struct {
        logic [3:0] foo;
        logic [2:0] len;
    } arr_t;

    vec_t vecs[$];
    int   split_idx;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic iv, input logic din, input logic fl,
                                input logic ordy, input logic rdy, input logic ov,
                                input logic [3:0] foo, input logic [2:0] len);
        vec_t v;
        v.iv = iv; v.din = din; v.fl = fl; v.ordy = ordy;
        v.exp_rdy = rdy; v.exp_ov = ov; v.exp_foo = foo; v.exp_len = len;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int n);
        @(negedge clk);
        bus4.in_valid  = v.iv;
        bus4.in_bit    = v.din;
        bus4.flush     = v.fl;
        bus4.out_ready = v.ordy;
        @(posedge clk);
        #1;
        check($sformatf("v%0d in_ready", n), 32'(bus4.in_ready), 32'(v.exp_rdy));
        check($sformatf("v%0d out_valid", n), 32'(bus4.out_valid), 32'(v.exp_ov));
        if (v.exp_ov) begin
            check($sformatf("v%0d out_foo", n), 32'(foo4), 32'(v.exp_foo));
            check($sformatf("v%0d out_len", n), 32'(bus4.out_len), 32'(v.exp_len));
        end
    endtask

    initial begin
        arr_t       q[$];
        arr_t       a;
        logic [3:0] cur;
        int         cnt;
        int         c;
        int         popped;
        logic       iv, din, fl, ordy, acc;

        // ---- vector table ----
        // Full array with out_ready high: 1,0,1,1.
        add(1,1,0,1, 1,0,4'h0,0);
        add(1,0,0,1, 1,0,4'h0,0);
        add(1,1,0,1, 1,0,4'h0,0);
        add(1,1,0,1, 1,1,4'b1101,4);
        add(0,0,0,1, 1,0,4'h0,0);
        // Backpressure: 1,1,1,1 held, 0,1,0,1 parks in FULL; flush/valid ignored in FULL.
        add(1,1,0,0, 1,0,4'h0,0);
        add(1,1,0,0, 1,0,4'h0,0);
        add(1,1,0,0, 1,0,4'h0,0);
        add(1,1,0,0, 1,1,4'b1111,4);
        add(1,0,0,0, 1,1,4'b1111,4);
        add(1,1,0,0, 1,1,4'b1111,4);
        add(1,0,0,0, 1,1,4'b1111,4);
        add(1,1,0,0, 0,1,4'b1111,4);
        add(0,0,1,0, 0,1,4'b1111,4);
        add(1,1,1,0, 0,1,4'b1111,4);
        add(0,0,0,1, 1,1,4'b1010,4);
        add(0,0,0,1, 1,0,4'h0,0);
        // Flush with a bit in the same cycle; flush with nothing pending; flush without a bit.
        add(1,1,0,1, 1,0,4'h0,0);
        add(1,1,0,1, 1,0,4'h0,0);
        add(1,0,1,1, 1,1,4'b0011,3);
        add(0,0,1,1, 1,0,4'h0,0);
        add(0,0,1,1, 1,0,4'h0,0);
        add(1,1,0,1, 1,0,4'h0,0);
        add(0,0,1,1, 1,1,4'b0001,1);
        add(0,0,0,1, 1,0,4'h0,0);
        // Drain and completion in the same cycle: new array replaces old, out_valid stays 1.
        add(1,1,1,0, 1,1,4'b0001,1);
        add(1,0,1,1, 1,1,4'b0000,1);
        add(1,1,1,1, 1,1,4'b0001,1);
        add(0,0,0,1, 1,0,4'h0,0);
        split_idx = vecs.size();
        // After reset mid-fill: 1,0,0,1 with no leftover data.
        add(1,1,0,1, 1,0,4'h0,0);
        add(1,0,0,1, 1,0,4'h0,0);
        add(1,0,0,1, 1,0,4'h0,0);
        add(1,1,0,1, 1,1,4'b1001,4);
        add(0,0,0,1, 1,0,4'h0,0);

        bus4.in_valid = 0; bus4.in_bit = 0; bus4.flush = 0; bus4.out_ready = 0;
        bus1.in_valid = 0; bus1.in_bit = 0; bus1.flush = 0; bus1.out_ready = 0;

        // ---- reset state ----
        #12;
        check("rst in_ready", 32'(bus4.in_ready), 32'd1);
        check("rst out_valid", 32'(bus4.out_valid), 32'd0);
        check("rst out_foo", 32'(foo4), 32'd0);
        check("rst out_len", 32'(bus4.out_len), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < split_idx; i++) apply(vecs[i], i);

        // ---- asynchronous reset after two accepted bits ----
        begin
            vec_t v;
            v.iv = 1; v.din = 1; v.fl = 0; v.ordy = 1;
            v.exp_rdy = 1; v.exp_ov = 0; v.exp_foo = 0; v.exp_len = 0;
            apply(v, 900);
            v.din = 1;
            apply(v, 901);
        end
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(bus4.out_valid), 32'd0);
        check("async rst out_foo", 32'(foo4), 32'd0);
        check("async rst out_len", 32'(bus4.out_len), 32'd0);
        check("async rst in_ready", 32'(bus4.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus4.in_valid = 0;

        for (int i = split_idx; i < vecs.size(); i++) apply(vecs[i], i);

        // ---- W=1: every bit is an array ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus1.in_valid  = 1;
            bus1.in_bit    = (i != 1);
            bus1.out_ready = 1;
            @(posedge clk);
            #1;
            check($sformatf("w1 b%0d out_valid", i), 32'(bus1.out_valid), 32'd1);
            check($sformatf("w1 b%0d out_foo", i), 32'(bus1.out_foo[0]), 32'(i != 1));
            check($sformatf("w1 b%0d out_len", i), 32'(bus1.out_len), 32'd1);
            check($sformatf("w1 b%0d in_ready", i), 32'(bus1.in_ready), 32'd1);
        end
        @(negedge clk);
        bus1.in_valid = 0;
        @(posedge clk);
        #1;
        check("w1 idle out_valid", 32'(bus1.out_valid), 32'd0);

        // ---- random handshake scoreboard, W=4 ----
        cur = '0; cnt = 0; popped = 0;
        for (int cyc = 0; cyc < 6000 && popped < 100; cyc++) begin
            @(negedge clk);
            ordy = 1'($urandom_range(0, 1));
            if (bus4.out_valid && ordy) begin
                if (q.size() == 0) begin
                    check("rand unexpected array", 32'd1, 32'd0);
                end else begin
                    a = q.pop_front();
                    check($sformatf("rand arr%0d foo", popped), 32'(foo4), 32'(a.foo));
                    check($sformatf("rand arr%0d len", popped), 32'(bus4.out_len), 32'(a.len));
                end
                popped++;
            end
            iv  = ($urandom_range(0, 3) != 0);
            din = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 7) == 0);
            if (bus4.in_ready) begin
                acc = iv;
                c   = cnt + int'(acc);
                if (acc) cur[cnt] = din;
                if ((acc && cnt == 3) || (fl && c > 0)) begin
                    a.foo = cur;
                    a.len = 3'(c);
                    q.push_back(a);
                    cur = '0;
                    cnt = 0;
                end else begin
                    cnt = c;
                end
            end
            bus4.in_valid  = iv;
            bus4.in_bit    = din;
            bus4.flush     = fl;
            bus4.out_ready = ordy;
        end
        check("rand arrays received", 32'(popped), 32'd100);

        // Drain whatever completed arrays remain; none may be lost or invented.
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            bus4.in_valid  = 0;
            bus4.flush     = 0;
            bus4.out_ready = 1;
            if (bus4.out_valid) begin
                if (q.size() == 0) begin
                    check("drain unexpected array", 32'd1, 32'd0);
                end else begin
                    a = q.pop_front();
                    check("drain foo", 32'(foo4), 32'(a.foo));
                    check("drain len", 32'(bus4.out_len), 32'(a.len));
                end
            end
        end
        check("drain queue empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
